// File: rtl/gauss5x5_window_if.sv
// gauss5x5_window_if: row-tap input and smoothed-pixel output bundle of the Gaussian window stage
interface gauss5x5_window_if;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] d1;
  logic [7:0] d2;
  logic [7:0] d3;
  logic [7:0] d4;
  logic [7:0] d5;
  logic       out_valid;
  logic       out_sof;
  logic [7:0] out_pix;
  modport master (output in_valid, in_sof, d1, d2, d3, d4, d5, input out_valid, out_sof, out_pix);
  modport slave (input in_valid, in_sof, d1, d2, d3, d4, d5, output out_valid, out_sof, out_pix);
endinterface

// File: rtl/gauss5x5_window.sv
// gauss5x5_window: separable 1-4-6-4-1 Gaussian over a 5x5 window built from line-buffer taps,
// with pixels whose window is incomplete or wraps a line forced to BORDER_VAL
module gauss5x5_window #(
  parameter int         IMG_W      = 514,
  parameter int         IMG_H      = 480,
  parameter logic [7:0] BORDER_VAL = 8'd0
) (
  input logic clk,
  input logic rst,
  gauss5x5_window_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] r_col, w_col;
  logic [RW-1:0] r_row, w_row;
  logic [11:0]   r_v [5];
  logic [11:0]   w_vsum;
  logic          r_s1_valid, r_s1_sof, r_s1_border;
  logic [15:0]   r_hsum;
  logic          r_s2_valid, r_s2_sof, r_s2_border;
  logic          r_valid, r_sof;
  logic [7:0]    r_pix;
  // counters hold the position of the next pixel; sof overrides it with (0,0)
  assign w_col  = bus.in_sof ? '0 : r_col;
  assign w_row  = bus.in_sof ? '0 : r_row;
  assign w_vsum = 12'(bus.d1) + 12'(bus.d2) * 12'd4 + 12'(bus.d3) * 12'd6
                + 12'(bus.d4) * 12'd4 + 12'(bus.d5);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_v         <= '{default: '0};
      r_s1_valid  <= 1'b0;
      r_s1_sof    <= 1'b0;
      r_s1_border <= 1'b0;
      r_hsum      <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_sof    <= 1'b0;
      r_s2_border <= 1'b0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_pix       <= '0;
    end else begin
      r_s1_valid <= bus.in_valid;
      r_s1_sof   <= bus.in_valid && bus.in_sof;
      if (bus.in_valid) begin
        r_v         <= '{r_v[1], r_v[2], r_v[3], r_v[4], w_vsum};
        r_s1_border <= (w_row < RW'(4)) || (w_col < CW'(4));
        r_col       <= (w_col == CW'(IMG_W - 1)) ? '0 : w_col + CW'(1);
        r_row       <= (w_col != CW'(IMG_W - 1)) ? w_row :
                       (w_row == RW'(IMG_H - 1)) ? '0 : w_row + RW'(1);
      end
      r_hsum      <= 16'(r_v[0]) + 16'(r_v[1]) * 16'd4 + 16'(r_v[2]) * 16'd6
                   + 16'(r_v[3]) * 16'd4 + 16'(r_v[4]);
      r_s2_valid  <= r_s1_valid;
      r_s2_sof    <= r_s1_sof;
      r_s2_border <= r_s1_border;
      r_valid     <= r_s2_valid;
      r_sof       <= r_s2_sof;
      if (r_s2_valid) r_pix <= r_s2_border ? BORDER_VAL : 8'((17'(r_hsum) + 17'd128) >> 8);
    end
  end
  assign bus.out_valid = r_valid;
  assign bus.out_sof   = r_sof;
  assign bus.out_pix   = r_pix;
endmodule

// File: tb/tb_gauss5x5_window.sv
// tb_gauss5x5_window: directed frames (flat, saturated, impulse, gaps, row wrap, mid-frame reset)
// on a reduced 16x12 image, checked against hand-derived pixel values
module tb_gauss5x5_window;
  localparam int W = 16;
  localparam int H = 12;
  // 255 impulse on the centre row: 255*6*{1,4,6,4,1}/256, rounded half-up
  localparam int IMP [5] = '{6, 24, 36, 24, 6};
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [8:0] got_q [$];
  int         got_cyc [$];
  gauss5x5_window_if bus ();
  gauss5x5_window #(.IMG_W(W), .IMG_H(H), .BORDER_VAL(8'd0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.out_valid === 1'b1) begin
    got_q.push_back({bus.out_sof, bus.out_pix});
    got_cyc.push_back(cyc);
  end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input bit v, input bit s, input logic [7:0] t, input logic [7:0] c);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.d1 = t;
    bus.d2 = t;
    bus.d3 = c;
    bus.d4 = t;
    bus.d5 = t;
    @(negedge clk);
  endtask
  function automatic int exp_px(input int i, input int val, input int imp, input bit sof);
    int row, col, off, px;
    row = (i / W) % H;
    col = i % W;
    off = i - imp;
    px  = (imp >= 0 && off >= 0 && off < 5) ? IMP[off] : val;
    if (row < 4 || col < 4) px = 0;
    return (int'(sof) << 8) | px;
  endfunction
  task automatic run_frame(input string tag, input int n, input int val, input int imp,
                           input int max_gap, input bit sof);
    int first_in;
    first_in = 0;
    got_q.delete();
    got_cyc.delete();
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(0, max_gap)) drive(0, 0, 8'd0, 8'd0);
      if (i == 0) first_in = cyc;
      drive(1, sof && i == 0, 8'(val), (i == imp) ? 8'd255 : 8'(val));
    end
    repeat (6) drive(0, 0, 8'd0, 8'd0);
    check({tag, "_count"}, got_q.size(), n);
    if (got_cyc.size() > 0) check({tag, "_latency"}, got_cyc[0] - first_in, 3);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check($sformatf("%s_px%0d", tag, i), int'(got_q[i]), exp_px(i, val, imp, sof && i == 0));
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.d1 = '0;
    bus.d2 = '0;
    bus.d3 = '0;
    bus.d4 = '0;
    bus.d5 = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_sof", int'(bus.out_sof), 0);
    check("rst_pix", int'(bus.out_pix), 0);
    rst = 1'b1;
    repeat (2) drive(0, 0, 8'd0, 8'd0);
    run_frame("flat100", W * H, 100, -1, 0, 1);
    run_frame("nosof_wrap", W * H, 100, -1, 0, 0);
    run_frame("flat255", W * H, 255, -1, 0, 1);
    run_frame("impulse", W * H, 0, 5 * W + 6, 0, 1);
    run_frame("impulse_gaps", W * H, 0, 5 * W + 6, 7, 1);
    run_frame("row_wrap", 5 * W + 6, 50, -1, 0, 1);
    for (int i = 0; i < 5 * W + 8; i++) drive(1, i == 0, 8'd100, 8'd100);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_valid", int'(bus.out_valid), 1);
    check("pre_rst_pix", int'(bus.out_pix), 100);
    rst = 1'b0;
    #1;
    check("async_rst_valid", int'(bus.out_valid), 0);
    check("async_rst_sof", int'(bus.out_sof), 0);
    check("async_rst_pix", int'(bus.out_pix), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    repeat (5) drive(0, 0, 8'd0, 8'd0);
    check("post_rst_idle", got_q.size(), 0);
    run_frame("post_rst", W * H, 100, -1, 0, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
